// File: rtl/ifid_stall_ctrl_pkg.sv
// Shared definitions for the IF/ID front-end sequencing controller:
// FSM state encoding, register-index width and parameter defaults.
package ifid_stall_ctrl_pkg;

  localparam int REG_W        = 5;
  localparam int MD_LAT_DEF   = 4;
  localparam int MISS_TMO_DEF = 255;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_MISS   = 2'd1;
  localparam logic [1:0] ST_REPLAY = 2'd2;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic refill_abort;
  } front_ctrl_t;

  localparam front_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0,
                                         ifid_flush: 1'b1, idex_bubble: 1'b1,
                                         refill_abort: 1'b0};

endpackage

// File: rtl/ifid_hazard_detect.sv
// Load-use hazard compare between the EX load destination and the ID sources.
// Purely combinational so the forwarding unit can reuse it.
module ifid_hazard_detect
  import ifid_stall_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read & (ex_rt != '0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/ifid_stall_ctrl.sv
// IF/ID + PC sequencing controller: RUN/MISS/REPLAY FSM, mult/div stall and miss timeout.
// Optional stall cycle counter with perf_clr when STALL_PERF_EN is defined.
module ifid_stall_ctrl
  import ifid_stall_ctrl_pkg::*;
#(
  parameter int MD_LAT   = MD_LAT_DEF,
  parameter int MISS_TMO = MISS_TMO_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             icache_hit,
  input  logic             icache_ready,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             branch_taken,
  input  logic             md_start,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             refill_abort,
  output logic             miss_pending,
  output logic             timeout_err
`ifdef STALL_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      stall_cycles
`endif
);

  localparam logic [3:0]  MD_LOAD  = 4'(MD_LAT - 1);
  localparam logic [15:0] TMO_LAST = 16'(MISS_TMO - 1);

  logic [1:0]  state, state_nxt;
  logic [3:0]  md_cnt, md_nxt;
  logic [15:0] tmo_cnt, tmo_nxt;
  logic        tmo_hit;
  logic        load_use;
  front_ctrl_t ctrl;

  ifid_hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    md_nxt    = md_cnt;
    tmo_nxt   = tmo_cnt;
    tmo_hit   = 1'b0;
    case (state)
      ST_RUN: begin
        if (branch_taken) begin
          ctrl.pc_write    = 1'b1;
          ctrl.ifid_flush  = 1'b1;
          ctrl.idex_bubble = 1'b1;
          md_nxt           = '0;
        end else begin
          if (md_cnt != '0) begin
            ctrl.idex_bubble = 1'b1;
            md_nxt           = md_cnt - 4'd1;
          end else if (load_use) begin
            ctrl.idex_bubble = 1'b1;
          end else if (!icache_hit) begin
            // ID keeps its instruction flowing; only the fetch slot is emptied.
            ctrl.ifid_flush = 1'b1;
            state_nxt       = ST_MISS;
            tmo_nxt         = '0;
          end else begin
            ctrl.pc_write   = 1'b1;
            ctrl.ifid_write = 1'b1;
          end
          // md_start belongs to the EX instruction, so it stacks with any ID-side stall.
          if (md_start) md_nxt = MD_LOAD;
        end
      end
      ST_MISS: begin
        ctrl.ifid_flush = 1'b1;
        if (tmo_cnt != 16'hFFFF) tmo_nxt = tmo_cnt + 16'd1;
        if (tmo_cnt == TMO_LAST) tmo_hit = 1'b1;
        if (branch_taken) begin
          ctrl.pc_write     = 1'b1;
          ctrl.refill_abort = 1'b1;
          state_nxt         = ST_RUN;
        end else if (icache_ready) begin
          state_nxt = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        ctrl.ifid_flush = 1'b1;
        state_nxt       = ST_RUN;
        if (branch_taken) begin
          ctrl.pc_write    = 1'b1;
          ctrl.idex_bubble = 1'b1;
          md_nxt           = '0;
        end
      end
      default: begin
        ctrl      = CTRL_RESET;
        state_nxt = ST_RUN;
      end
    endcase
    // Reset overrides combinationally so the pipeline sees NOPs without waiting for a clock.
    if (!rstn) ctrl = CTRL_RESET;
  end

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_bubble  = ctrl.idex_bubble;
  assign refill_abort = ctrl.refill_abort;
  assign miss_pending = (state == ST_MISS) | (state == ST_REPLAY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_RUN;
      md_cnt      <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      md_cnt      <= md_nxt;
      tmo_cnt     <= tmo_nxt;
      timeout_err <= timeout_err | tmo_hit;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (!ctrl.pc_write && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_stall_ctrl.sv
// Scoreboard bench for ifid_stall_ctrl: two instances (MD_LAT=4 and MD_LAT=1, MISS_TMO=5)
// share randomized stimulus; a high-level model queues expected outputs, a monitor compares at negedge.
module tb_ifid_stall_ctrl;

  localparam int TMO = 5;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic refill_abort;
    logic miss_pending;
    logic timeout_err;
  } obs_t;

  typedef struct packed {
    obs_t        o;
    logic [31:0] stall;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       icache_hit = 1'b1, icache_ready = 1'b0, ex_mem_read = 1'b0;
  logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic       id_uses_rt = 1'b0, branch_taken = 1'b0, md_start = 1'b0;
  logic [6:0] o0, o1;
  obs_t       a0, a1;
`ifdef STALL_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] stall_cycles;
  logic [31:0] m_stall = '0;
`endif

  int passes = 0;
  int checks = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  // model state per instance: 0 -> MD_LAT=4, 1 -> MD_LAT=1
  int m_md_lat[2] = '{4, 1};
  bit m_miss[2];
  bit m_replay[2];
  int m_age[2];
  int m_md_left[2];
  bit m_tmo[2];

  always #5 clk = ~clk;

  ifid_stall_ctrl #(.MD_LAT(4), .MISS_TMO(TMO)) u_dut0 (
    .clk(clk), .rstn(rstn), .icache_hit(icache_hit), .icache_ready(icache_ready),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .md_start(md_start),
    .pc_write(o0[6]), .ifid_write(o0[5]), .ifid_flush(o0[4]), .idex_bubble(o0[3]),
    .refill_abort(o0[2]), .miss_pending(o0[1]), .timeout_err(o0[0])
`ifdef STALL_PERF_EN
    , .perf_clr(perf_clr), .stall_cycles(stall_cycles)
`endif
  );

  ifid_stall_ctrl #(.MD_LAT(1), .MISS_TMO(TMO)) u_dut1 (
    .clk(clk), .rstn(rstn), .icache_hit(icache_hit), .icache_ready(icache_ready),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .branch_taken(branch_taken), .md_start(md_start),
    .pc_write(o1[6]), .ifid_write(o1[5]), .ifid_flush(o1[4]), .idex_bubble(o1[3]),
    .refill_abort(o1[2]), .miss_pending(o1[1]), .timeout_err(o1[0])
`ifdef STALL_PERF_EN
    , .perf_clr(), .stall_cycles()
`endif
  );

  assign a0 = obs_t'(o0);
  assign a1 = obs_t'(o1);

  // Reference: the controller's rules stated over "is a miss outstanding, how long, how many md cycles left".
  task automatic model(input int i, output obs_t e);
    bit lu;
    e = '0;
    if (!rstn) begin
      e.ifid_flush = 1'b1;
      e.idex_bubble = 1'b1;
      m_miss[i] = 0; m_replay[i] = 0; m_age[i] = 0; m_md_left[i] = 0; m_tmo[i] = 0;
      return;
    end
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e.timeout_err  = m_tmo[i];
    e.miss_pending = m_miss[i] || m_replay[i];
    if (m_replay[i]) begin
      e.ifid_flush = 1'b1;
      if (branch_taken) begin
        e.pc_write = 1'b1; e.idex_bubble = 1'b1; m_md_left[i] = 0;
      end
      m_replay[i] = 0;
    end else if (m_miss[i]) begin
      e.ifid_flush = 1'b1;
      if (m_age[i] + 1 == TMO) m_tmo[i] = 1;
      m_age[i]++;
      if (branch_taken) begin
        e.pc_write = 1'b1; e.refill_abort = 1'b1; m_miss[i] = 0;
      end else if (icache_ready) begin
        m_miss[i] = 0; m_replay[i] = 1;
      end
    end else if (branch_taken) begin
      e.pc_write = 1'b1; e.ifid_flush = 1'b1; e.idex_bubble = 1'b1; m_md_left[i] = 0;
    end else begin
      if (m_md_left[i] > 0) begin
        e.idex_bubble = 1'b1; m_md_left[i]--;
      end else if (lu) begin
        e.idex_bubble = 1'b1;
      end else if (!icache_hit) begin
        e.ifid_flush = 1'b1; m_miss[i] = 1; m_age[i] = 0;
      end else begin
        e.pc_write = 1'b1; e.ifid_write = 1'b1;
      end
      if (md_start) m_md_left[i] = m_md_lat[i] - 1;
    end
  endtask

  task automatic drive(input bit hit, input bit rdy, input bit mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                       input bit br, input bit md, input bit rn);
    exp_t e0, e1;
    obs_t o;
    @(posedge clk);
    #1;
    cyc++;
    rstn = rn; icache_hit = hit; icache_ready = rdy; ex_mem_read = mr; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; branch_taken = br; md_start = md;
    model(0, o);
    e0.o = o; e0.cyc = cyc; e0.stall = '0;
`ifdef STALL_PERF_EN
    perf_clr = ($urandom_range(0, 63) == 0);
    e0.stall = rn ? m_stall : '0;
    if (!rn || perf_clr) m_stall = '0;
    else if (!o.pc_write && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
    model(1, o);
    e1.o = o; e1.cyc = cyc; e1.stall = '0;
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic reset_now_check(input string name);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (a0 === 7'b0011000) passes++;
    else $display("FAIL %s: outputs=%b required=%b", name, a0, 7'b0011000);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      checks++;
      if (a0 === e.o) passes++;
      else $display("FAIL dut0_ctrl cyc=%0d: got %b required %b", e.cyc, a0, e.o);
`ifdef STALL_PERF_EN
      checks++;
      if (stall_cycles === e.stall) passes++;
      else $display("FAIL stall_cycles cyc=%0d: got %0d required %0d", e.cyc, stall_cycles, e.stall);
`endif
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if (a1 === e.o) passes++;
      else $display("FAIL dut1_ctrl cyc=%0d: got %b required %b", e.cyc, a1, e.o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    // load-use on rs, then the same pattern through r0
    drive(1, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 1);
    idle(2);
    drive(1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1);
    drive(1, 0, 1, 5'd9, 5'd2, 5'd9, 1, 0, 0, 1);
    idle(1);
    // miss: hit low once, refill completes on the third miss cycle
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // mult/div start
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(5);
    // branch together with refill completion during a miss
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    // branch in replay
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(2);
    // timeout: stay in miss past the limit, then leave by branch
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(3);
    // reset during miss
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_now_check("reset_in_miss");
    idle(3);
    // reset during md stall
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_now_check("reset_in_md_stall");
    idle(4);
    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 299) != 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() == 0 && q1.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: left=%0d/%0d required=0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
